// File: rtl/gcd_pkg.sv
// rtl/gcd_pkg.sv - shared state encoding, mode constants and datapath op codes for gcd_engine
package gcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic MODE_EUCLID = 1'b0;
  localparam logic MODE_STEIN  = 1'b1;

  // One op per cycle; the control FSM picks exactly one of these in CALC.
  typedef enum logic [3:0] {
    OP_HOLD        = 4'd0,
    OP_LOAD        = 4'd1,
    OP_SWAP        = 4'd2,
    OP_SUB         = 4'd3,
    OP_HALVE_AB    = 4'd4,
    OP_HALVE_A     = 4'd5,
    OP_HALVE_B     = 4'd6,
    OP_SUB_AB_HALF = 4'd7,
    OP_SUB_BA_HALF = 4'd8
  } dp_op_e;

endpackage

// File: rtl/gcd_datapath.sv
// rtl/gcd_datapath.sv - A/B/k operand registers, step arithmetic, status flags and result register
module gcd_datapath
  import gcd_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  dp_op_e       op,
  input  logic         res_en,
  input  logic         res_stein,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic [W-1:0] result,
  output logic         a_lt_b,
  output logic         a_zero,
  output logic         b_zero,
  output logic         a_even,
  output logic         b_even
);
  localparam int KW = $clog2(W + 1);

  logic [W-1:0]  a_q, a_d, b_q, b_d, res_q, res_d;
  logic [KW-1:0] k_q, k_d;
  logic [W-1:0]  diff_ab, diff_ba;

  // Both differences are built, but the FSM only selects the non-negative one.
  assign diff_ab = a_q - b_q;
  assign diff_ba = b_q - a_q;

  assign a_lt_b = (a_q < b_q);
  assign a_zero = (a_q == '0);
  assign b_zero = (b_q == '0);
  assign a_even = ~a_q[0];
  assign b_even = ~b_q[0];
  assign result = res_q;

  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    k_d   = k_q;
    res_d = res_q;
    case (op)
      OP_LOAD: begin
        a_d = in_a;
        b_d = in_b;
        k_d = '0;
      end
      OP_SWAP: begin
        a_d = b_q;
        b_d = a_q;
      end
      OP_SUB:         a_d = diff_ab;
      OP_HALVE_AB: begin
        a_d = a_q >> 1;
        b_d = b_q >> 1;
        k_d = k_q + 1'b1;
      end
      OP_HALVE_A:     a_d = a_q >> 1;
      OP_HALVE_B:     b_d = b_q >> 1;
      OP_SUB_AB_HALF: a_d = diff_ab >> 1;
      OP_SUB_BA_HALF: b_d = diff_ba >> 1;
      default: ;
    endcase
    // The restored power of two cannot overflow: the true gcd always fits in W bits.
    if (res_en) res_d = res_stein ? ((a_q | b_q) << k_q) : a_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q   <= '0;
      b_q   <= '0;
      k_q   <= '0;
      res_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      k_q   <= k_d;
      res_q <= res_d;
    end
  end

endmodule

// File: rtl/gcd_engine.sv
// rtl/gcd_engine.sv - GCD engine top: request/response handshake, control FSM and cycle counter
module gcd_engine
  import gcd_pkg::*;
#(
  parameter int W     = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_val,
  output logic             req_rdy,
  input  logic [W-1:0]     req_a,
  input  logic [W-1:0]     req_b,
  input  logic             req_mode,
  output logic             resp_val,
  input  logic             resp_rdy,
  output logic [W-1:0]     resp_gcd,
  output logic [CNT_W-1:0] resp_cycles,
  output logic             busy
);
  state_e           state_q, state_d;
  logic             mode_q, mode_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             req_rdy_q, resp_val_q, busy_q;
  dp_op_e           dp_op;
  logic             res_en;
  logic             a_lt_b, a_zero, b_zero, a_even, b_even;

  gcd_datapath #(.W(W)) u_datapath (
    .clk       (clk),
    .reset     (reset),
    .op        (dp_op),
    .res_en    (res_en),
    .res_stein (mode_q),
    .in_a      (req_a),
    .in_b      (req_b),
    .result    (resp_gcd),
    .a_lt_b    (a_lt_b),
    .a_zero    (a_zero),
    .b_zero    (b_zero),
    .a_even    (a_even),
    .b_even    (b_even)
  );

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    dp_op   = OP_HOLD;
    res_en  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_val && req_rdy_q) begin
          dp_op   = OP_LOAD;
          mode_d  = req_mode;
          cnt_d   = '0;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        if (mode_q == MODE_EUCLID) begin
          if (a_lt_b)       dp_op = OP_SWAP;
          else if (!b_zero) dp_op = OP_SUB;
          else begin
            res_en  = 1'b1;
            state_d = ST_DONE;
          end
        end else begin
          if (a_zero || b_zero) begin
            res_en  = 1'b1;
            state_d = ST_DONE;
          end
          else if (a_even && b_even) dp_op = OP_HALVE_AB;
          else if (a_even)           dp_op = OP_HALVE_A;
          else if (b_even)           dp_op = OP_HALVE_B;
          else if (!a_lt_b)          dp_op = OP_SUB_AB_HALF;
          else                       dp_op = OP_SUB_BA_HALF;
        end
      end
      ST_DONE: begin
        if (resp_rdy) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs are flops loaded from the next state, so they track state_q exactly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      mode_q     <= MODE_EUCLID;
      cnt_q      <= '0;
      req_rdy_q  <= 1'b1;
      resp_val_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      cnt_q      <= cnt_d;
      req_rdy_q  <= (state_d == ST_IDLE);
      resp_val_q <= (state_d == ST_DONE);
      busy_q     <= (state_d != ST_IDLE);
    end
  end

  assign req_rdy     = req_rdy_q;
  assign resp_val    = resp_val_q;
  assign busy        = busy_q;
  assign resp_cycles = cnt_q;

endmodule

// File: doc/gcd_engine.md
GCD_ENGINE -- requirements
Module: gcd_engine

Interface
REQ-001 Parameter W, default 16, operand and result width in bits (W >= 2).
REQ-002 Parameter CNT_W, default 16, width of the cycle-count output.
REQ-003 Port clk  in  1  sole clock; all state changes on rising edge.
REQ-004 Port reset  in  1  asynchronous, active-high reset.
REQ-005 Port req_val  in  1  request operands valid.
REQ-006 Port req_rdy  out  1  engine can accept a request.
REQ-007 Port req_a  in  W  operand A, unsigned.
REQ-008 Port req_b  in  W  operand B, unsigned.
REQ-009 Port req_mode  in  1  0 = subtractive Euclid, 1 = binary (Stein).
REQ-010 Port resp_val  out  1  result valid.
REQ-011 Port resp_rdy  in  1  consumer accepts result.
REQ-012 Port resp_gcd  out  W  gcd(A,B); gcd(x,0) = x, gcd(0,0) = 0.
REQ-013 Port resp_cycles  out  CNT_W  number of CALC cycles spent, saturating at all-ones.
REQ-014 Port busy  out  1  high in CALC or DONE.

Function
REQ-015 FSM states IDLE, CALC, DONE; registered outputs req_rdy = (state==IDLE), resp_val = (state==DONE), busy = (state!=IDLE).
REQ-016 IDLE: on req_val && req_rdy, latch A, B, mode; clear shift count k and cycle counter; go to CALC next cycle.
REQ-017 CALC: each cycle increments the cycle counter (saturating) and performs exactly one step of the latched mode.
REQ-018 Euclid step, priority order: A<B -> swap A,B; else B!=0 -> A=A-B; else -> result=A, go DONE.
REQ-019 Stein step, priority order: A==0 or B==0 -> result=(A|B)<<k, go DONE; both even -> A>>=1, B>>=1, k++; A even -> A>>=1; B even -> B>>=1; A>=B -> A=(A-B)>>1; else B=(B-A)>>1.
REQ-020 k width is clog2(W+1); the final shift never exceeds W bits and never overflows, since the true gcd fits in W bits.
REQ-021 All arithmetic is unsigned W-bit; subtraction is performed only when its result is non-negative.
REQ-022 DONE: resp_gcd and resp_cycles remain stable while resp_val=1 && resp_rdy=0; on resp_rdy go to IDLE next cycle.
REQ-023 No new request is accepted in CALC or DONE; req_val there is ignored and does not need to be held.
REQ-024 Back-to-back: a request may be accepted in the first IDLE cycle after the DONE handshake.
REQ-025 Mode and operand ports are sampled only at acceptance; changes during CALC have no effect.
REQ-026 gcd(0,0) completes in 1 CALC cycle with result 0 in both modes.

Reset
REQ-027 Asserting reset at any time, including mid-CALC or in DONE, immediately forces state IDLE, req_rdy=1, resp_val=0, busy=0, resp_gcd=0, resp_cycles=0, k=0.
REQ-028 The first acceptance after reset deasserts occurs no earlier than the first rising clk edge with reset low.

Structure
REQ-029 Shared package gcd_pkg holds the state encoding (IDLE=0, CALC=1, DONE=2) and the mode constants MODE_EUCLID=0 and MODE_STEIN=1.
REQ-030 Sub-module gcd_datapath (A/B/k registers, comparator, subtractor, shifters, result register) is driven by a control FSM in gcd_engine through select/enable signals and returns the status flags a_lt_b, a_zero, b_zero, a_even, b_even.

Verification
REQ-031 Euclid (15,5) -> resp_gcd=5, resp_cycles=5, resp_val rises 6 cycles after acceptance.
REQ-032 Stein (12,18) -> resp_gcd=6, resp_cycles=5; Stein (0,0) and Euclid (0,0) -> 0, cycles=1.
REQ-033 Euclid (0,7) -> 7 via swap; Stein (W=16) (0x8000,0x4000) -> 0x4000, no overflow on the final shift.
REQ-034 Hold resp_rdy=0 for 10 cycles in DONE -> outputs stable and req_rdy=0 throughout; then a pulse on resp_rdy returns to IDLE and a back-to-back request is accepted on the next cycle.
REQ-035 Assert reset 3 cycles into CALC -> IDLE with all outputs at their reset values; the next request (9,6) returns 3.
REQ-036 Random sweep of both modes against a reference gcd model, with resp_rdy toggled randomly -> every result matches the model.
